id_stage: RTL and testbench

Parametrised instruction-decode stage for the 16-bit pipelined core. Decodes the IF/ID instruction and reads a 16-entry register file with optional write-to-read bypass. Results land in an internal ID/EX pipeline register with a valid/ready handshake, load-use bubble insertion, flush, sticky halt and a saturating bubble counter. Sits between the IF/ID register and EX.

---
 rtl/id_pkg.sv | 100 ++++++++++
 rtl/regfile_2r1w.sv | 55 +++++
 rtl/id_stage.sv | 127 ++++++++++++
 tb/tb_id_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, the decoded-control
// bundle and the combinational instruction decoder.
package id_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_ADDZ = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SRA  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hD;
    localparam logic [3:0] OP_JR   = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [3:0] LINK_REG = 4'hF;

    typedef struct packed {
        logic [3:0] rdReg1;
        logic [3:0] rdReg2;
        logic [3:0] wrReg;
        logic [3:0] aluOp;
        logic [3:0] shAmt;
        logic       memRd;
        logic       memWr;
        logic       wrRegEn;
        logic       aluSrc;
        logic       sawBr;
        logic       sawJ;
        logic       updateFlagsOnAdd;
        logic       isHlt;
    } ctrl_t;

    // A disabled read port carries address 0, so it reads as zero and never
    // matches a pending load destination in the hazard check.
    function automatic ctrl_t decode(input logic [15:0] instr, input logic z);
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic [3:0] rt;
        ctrl_t      c;
        op = instr[15:12];
        rd = instr[11:8];
        rs = instr[7:4];
        rt = instr[3:0];
        c = '0;
        c.aluOp = op;
        c.wrReg = rd;
        case (op)
            OP_ADD, OP_SUB: begin
                c.rdReg1 = rs; c.rdReg2 = rt; c.wrRegEn = 1'b1; c.updateFlagsOnAdd = 1'b1;
            end
            OP_ADDZ: begin
                c.rdReg1 = rs; c.rdReg2 = rt; c.wrRegEn = z; c.updateFlagsOnAdd = 1'b1;
            end
            OP_AND, OP_NOR: begin
                c.rdReg1 = rs; c.rdReg2 = rt; c.wrRegEn = 1'b1;
            end
            OP_SLL, OP_SRL, OP_SRA: begin
                c.rdReg1 = rs; c.shAmt = rt; c.wrRegEn = 1'b1; c.aluSrc = 1'b1;
            end
            OP_LW: begin
                c.rdReg1 = rs; c.memRd = 1'b1; c.wrRegEn = 1'b1; c.aluSrc = 1'b1;
            end
            OP_SW: begin
                c.rdReg1 = rs; c.rdReg2 = rd; c.memWr = 1'b1; c.aluSrc = 1'b1;
            end
            OP_LHB: begin
                c.rdReg1 = rd; c.wrRegEn = 1'b1; c.aluSrc = 1'b1;
            end
            OP_LLB: begin
                c.wrRegEn = 1'b1; c.aluSrc = 1'b1;
            end
            OP_B: begin
                c.sawBr = 1'b1;
            end
            OP_JAL: begin
                c.wrReg = LINK_REG; c.wrRegEn = 1'b1; c.sawJ = 1'b1;
            end
            OP_JR: begin
                c.rdReg1 = rs; c.sawJ = 1'b1;
            end
            OP_HLT: begin
                c = '0;
                c.isHlt = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 16-entry register file, two asynchronous read ports and one write port;
// R0 is hardwired to zero and optional write-to-read forwarding.
module regfile_2r1w #(
    parameter int DATA_W = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wrEn,
    input  logic [3:0]        i_wrReg,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [3:0]        i_rdReg0,
    input  logic [3:0]        i_rdReg1,
    output logic [DATA_W-1:0] o_rdData0,
    output logic [DATA_W-1:0] o_rdData1
);

    logic [DATA_W-1:0] regs_r [16];

    // Storage update; writes aimed at R0 are dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= '0;
            end
        end else if (i_wrEn && (i_wrReg != 4'd0)) begin
            regs_r[i_wrReg] <= i_wrData;
        end
    end

    // Read port 0 with R0 masking and optional forwarding of the write port.
    always_comb begin
        o_rdData0 = '0;
        if (i_rdReg0 == 4'd0) begin
            o_rdData0 = '0;
        end else if (BYPASS && i_wrEn && (i_wrReg == i_rdReg0)) begin
            o_rdData0 = i_wrData;
        end else begin
            o_rdData0 = regs_r[i_rdReg0];
        end
    end

    // Read port 1, same policy as port 0.
    always_comb begin
        o_rdData1 = '0;
        if (i_rdReg1 == 4'd0) begin
            o_rdData1 = '0;
        end else if (BYPASS && i_wrEn && (i_wrReg == i_rdReg1)) begin
            o_rdData1 = i_wrData;
        end else begin
            o_rdData1 = regs_r[i_rdReg1];
        end
    end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: decode, register read, load-use stall, ID/EX
// pipeline register with flush, sticky halt and a saturating bubble counter.
module id_stage
    import id_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter bit BYPASS = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic [15:0]       i_instr,
    output logic              o_ready,
    input  logic              i_flush,
    input  logic              i_exReady,
    input  logic              i_wrEn,
    input  logic [3:0]        i_wrReg,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_Z,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_port0,
    output logic [DATA_W-1:0] o_port1,
    output logic [3:0]        o_rdReg1,
    output logic [3:0]        o_rdReg2,
    output logic [3:0]        o_wrReg,
    output logic [3:0]        o_aluOp,
    output logic [3:0]        o_shAmt,
    output logic              o_memRd,
    output logic              o_memWr,
    output logic              o_mem2reg,
    output logic              o_wrRegEn,
    output logic              o_aluSrc,
    output logic              o_sawBr,
    output logic              o_sawJ,
    output logic              o_updateFlagsOnAdd,
    output logic              o_hlt,
    output logic [CNT_W-1:0]  o_bubbles
);

    ctrl_t             dec_s;
    logic [DATA_W-1:0] rdData0_s;
    logic [DATA_W-1:0] rdData1_s;
    logic              hazard_s;
    logic              advance_s;
    logic              bubbleInc_s;

    assign dec_s = decode(i_instr, i_Z);

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .BYPASS (BYPASS)
    ) uRegfile (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wrEn    (i_wrEn),
        .i_wrReg   (i_wrReg),
        .i_wrData  (i_wrData),
        .i_rdReg0  (dec_s.rdReg1),
        .i_rdReg1  (dec_s.rdReg2),
        .o_rdData0 (rdData0_s),
        .o_rdData1 (rdData1_s)
    );

    // Load-use detection against the load sitting in ID/EX, plus handshake.
    always_comb begin
        hazard_s    = o_valid && o_memRd && (o_wrReg != 4'd0) &&
                      ((dec_s.rdReg1 == o_wrReg) || (dec_s.rdReg2 == o_wrReg));
        advance_s   = i_exReady || !o_valid;
        o_ready     = i_valid && advance_s && !hazard_s && !o_hlt && !i_flush;
        bubbleInc_s = i_valid && advance_s && hazard_s && !i_flush && !o_hlt;
    end

    // ID/EX register, halt flag and bubble counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid            <= 1'b0;
            o_port0            <= '0;
            o_port1            <= '0;
            o_rdReg1           <= 4'd0;
            o_rdReg2           <= 4'd0;
            o_wrReg            <= 4'd0;
            o_aluOp            <= 4'd0;
            o_shAmt            <= 4'd0;
            o_memRd            <= 1'b0;
            o_memWr            <= 1'b0;
            o_mem2reg          <= 1'b0;
            o_wrRegEn          <= 1'b0;
            o_aluSrc           <= 1'b0;
            o_sawBr            <= 1'b0;
            o_sawJ             <= 1'b0;
            o_updateFlagsOnAdd <= 1'b0;
            o_hlt              <= 1'b0;
            o_bubbles          <= '0;
        end else begin
            if (i_flush) begin
                o_valid <= 1'b0;
            end else if (advance_s) begin
                o_valid <= o_ready;
                if (o_ready) begin
                    o_port0            <= rdData0_s;
                    o_port1            <= rdData1_s;
                    o_rdReg1           <= dec_s.rdReg1;
                    o_rdReg2           <= dec_s.rdReg2;
                    o_wrReg            <= dec_s.wrReg;
                    o_aluOp            <= dec_s.aluOp;
                    o_shAmt            <= dec_s.shAmt;
                    o_memRd            <= dec_s.memRd;
                    o_memWr            <= dec_s.memWr;
                    o_mem2reg          <= dec_s.memRd;
                    o_wrRegEn          <= dec_s.wrRegEn;
                    o_aluSrc           <= dec_s.aluSrc;
                    o_sawBr            <= dec_s.sawBr;
                    o_sawJ             <= dec_s.sawJ;
                    o_updateFlagsOnAdd <= dec_s.updateFlagsOnAdd;
                    if (dec_s.isHlt) begin
                        o_hlt <= 1'b1;
                    end
                end
            end
            if (bubbleInc_s && !(&o_bubbles)) begin
                o_bubbles <= o_bubbles + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: one bypassing instance and one non-bypassing
// instance share stimulus; expected values are hand-computed per step.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [15:0] instr;
    logic        flush;
    logic        exReady;
    logic        wrEn;
    logic [3:0]  wrReg;
    logic [15:0] wrData;
    logic        z;

    logic        ready, oValid, memRd, memWr, mem2reg, wrRegEn, aluSrc, sawBr, sawJ, updFlags, hlt;
    logic [15:0] port0, port1, bubbles;
    logic [3:0]  rdReg1, rdReg2, oWrReg, aluOp, shAmt;

    logic        nbReady, nbValid, nbMemRd, nbMemWr, nbMem2reg, nbWrRegEn, nbAluSrc, nbSawBr, nbSawJ, nbUpd, nbHlt;
    logic [15:0] nbPort0, nbPort1, nbBubbles;
    logic [3:0]  nbRdReg1, nbRdReg2, nbWrReg, nbAluOp, nbShAmt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_stage #(.DATA_W(16), .BYPASS(1'b1), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_instr(instr), .o_ready(ready),
        .i_flush(flush), .i_exReady(exReady), .i_wrEn(wrEn), .i_wrReg(wrReg),
        .i_wrData(wrData), .i_Z(z), .o_valid(oValid), .o_port0(port0), .o_port1(port1),
        .o_rdReg1(rdReg1), .o_rdReg2(rdReg2), .o_wrReg(oWrReg), .o_aluOp(aluOp),
        .o_shAmt(shAmt), .o_memRd(memRd), .o_memWr(memWr), .o_mem2reg(mem2reg),
        .o_wrRegEn(wrRegEn), .o_aluSrc(aluSrc), .o_sawBr(sawBr), .o_sawJ(sawJ),
        .o_updateFlagsOnAdd(updFlags), .o_hlt(hlt), .o_bubbles(bubbles)
    );

    id_stage #(.DATA_W(16), .BYPASS(1'b0), .CNT_W(16)) dutNb (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_instr(instr), .o_ready(nbReady),
        .i_flush(flush), .i_exReady(exReady), .i_wrEn(wrEn), .i_wrReg(wrReg),
        .i_wrData(wrData), .i_Z(z), .o_valid(nbValid), .o_port0(nbPort0), .o_port1(nbPort1),
        .o_rdReg1(nbRdReg1), .o_rdReg2(nbRdReg2), .o_wrReg(nbWrReg), .o_aluOp(nbAluOp),
        .o_shAmt(nbShAmt), .o_memRd(nbMemRd), .o_memWr(nbMemWr), .o_mem2reg(nbMem2reg),
        .o_wrRegEn(nbWrRegEn), .o_aluSrc(nbAluSrc), .o_sawBr(nbSawBr), .o_sawJ(nbSawJ),
        .o_updateFlagsOnAdd(nbUpd), .o_hlt(nbHlt), .o_bubbles(nbBubbles)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; instr = 16'h0000; flush = 1'b0; exReady = 1'b1;
        wrEn = 1'b0; wrReg = 4'd0; wrData = 16'h0000; z = 1'b0;
        tick();
        chk("rst_valid", oValid, 1'b0);
        chk("rst_port0", port0, 16'h0000);
        chk("rst_wrReg", oWrReg, 4'd0);
        chk("rst_hlt", hlt, 1'b0);
        chk("rst_bubbles", bubbles, 16'd0);
        rst = 1'b0;

        // preload R1=5, R2=7, R6=1111
        wrEn = 1'b1; wrReg = 4'd1; wrData = 16'd5;      tick();
        wrReg = 4'd2; wrData = 16'd7;                    tick();
        wrReg = 4'd6; wrData = 16'h1111;                 tick();
        wrEn = 1'b0;

        // ADD R3,R1,R2
        valid = 1'b1; instr = 16'h0312; settle();
        chk("add_ready", ready, 1'b1);
        tick();
        chk("add_valid", oValid, 1'b1);
        chk("add_port0", port0, 16'd5);
        chk("add_port1", port1, 16'd7);
        chk("add_wrReg", oWrReg, 4'd3);
        chk("add_aluOp", aluOp, 4'd0);
        chk("add_wrEn", wrRegEn, 1'b1);
        chk("add_flags", updFlags, 1'b1);

        // LW R4,[R1] then dependent ADD R5,R4,R2
        instr = 16'h8410; tick();
        chk("lw_memRd", memRd, 1'b1);
        chk("lw_mem2reg", mem2reg, 1'b1);
        chk("lw_wrReg", oWrReg, 4'd4);
        chk("lw_aluSrc", aluSrc, 1'b1);
        instr = 16'h0542; settle();
        chk("luse_ready0", ready, 1'b0);
        tick();
        chk("luse_bubble", oValid, 1'b0);
        chk("luse_count", bubbles, 16'd1);
        chk("luse_ready1", ready, 1'b1);
        tick();
        chk("luse_valid", oValid, 1'b1);
        chk("luse_wrReg", oWrReg, 4'd5);
        chk("luse_rdReg1", rdReg1, 4'd4);
        chk("luse_port1", port1, 16'd7);
        chk("luse_count2", bubbles, 16'd1);

        // ADD R7,R6,R0 with same-cycle write R6=BEEF
        instr = 16'h0760; wrEn = 1'b1; wrReg = 4'd6; wrData = 16'hBEEF; tick();
        chk("byp_new", port0, 16'hBEEF);
        chk("nobyp_old", nbPort0, 16'h1111);
        chk("byp_r0", port1, 16'h0000);
        wrEn = 1'b0;

        // stall with valid ID/EX, flush in second cycle
        exReady = 1'b0; instr = 16'h2861; settle();
        chk("stall_ready0", ready, 1'b0);
        tick();
        chk("stall_valid", oValid, 1'b1);
        chk("stall_wrReg", oWrReg, 4'd7);
        chk("stall_port0", port0, 16'hBEEF);
        flush = 1'b1; settle();
        chk("stall_ready1", ready, 1'b0);
        tick();
        chk("flush_valid", oValid, 1'b0);
        flush = 1'b0; settle();
        chk("empty_ready", ready, 1'b1);
        tick();
        chk("sub_valid", oValid, 1'b1);
        chk("sub_aluOp", aluOp, 4'd2);
        chk("sub_wrReg", oWrReg, 4'd8);
        chk("sub_port0", port0, 16'hBEEF);
        chk("sub_port1", port1, 16'd5);
        exReady = 1'b1;

        // flush while load-use hazard pending: no bubble counted
        instr = 16'h8910; tick();
        instr = 16'h0A91; flush = 1'b1; settle();
        chk("flhz_ready", ready, 1'b0);
        tick();
        chk("flhz_valid", oValid, 1'b0);
        chk("flhz_count", bubbles, 16'd1);
        flush = 1'b0;

        // ADDZ R11,R0,R1 with Z=0 and same-cycle write to R0
        instr = 16'h1B01; z = 1'b0; wrEn = 1'b1; wrReg = 4'd0; wrData = 16'h1234; tick();
        chk("addz_port0", port0, 16'h0000);
        chk("addz_port1", port1, 16'd5);
        chk("addz_wrEn", wrRegEn, 1'b0);
        chk("addz_flags", updFlags, 1'b1);
        wrEn = 1'b0;
        instr = 16'h1C01; z = 1'b1; tick();
        chk("r0_read", port0, 16'h0000);
        chk("addz1_wrEn", wrRegEn, 1'b1);

        // SW R6,[R1]
        instr = 16'h9610; tick();
        chk("sw_port0", port0, 16'd5);
        chk("sw_port1", port1, 16'hBEEF);
        chk("sw_rdReg2", rdReg2, 4'd6);
        chk("sw_memWr", memWr, 1'b1);
        chk("sw_wrEn", wrRegEn, 1'b0);

        // SLL R13,R1,3
        instr = 16'h5D13; tick();
        chk("sll_shAmt", shAmt, 4'd3);
        chk("sll_aluSrc", aluSrc, 1'b1);
        chk("sll_port1", port1, 16'h0000);
        chk("sll_flags", updFlags, 1'b0);

        // JAL, B
        instr = 16'hD000; tick();
        chk("jal_wrReg", oWrReg, 4'hF);
        chk("jal_sawJ", sawJ, 1'b1);
        chk("jal_wrEn", wrRegEn, 1'b1);
        instr = 16'hC000; tick();
        chk("b_sawBr", sawBr, 1'b1);
        chk("b_wrEn", wrRegEn, 1'b0);

        // HLT
        instr = 16'hF000; settle();
        chk("hlt_ready", ready, 1'b1);
        tick();
        chk("hlt_set", hlt, 1'b1);
        chk("hlt_valid", oValid, 1'b1);
        chk("hlt_aluOp", aluOp, 4'd0);
        chk("hlt_sawBr", sawBr, 1'b0);
        instr = 16'h0312; settle();
        chk("hlt_block0", ready, 1'b0);
        tick();
        chk("hlt_drain", oValid, 1'b0);
        chk("hlt_block1", ready, 1'b0);
        flush = 1'b1; tick();
        chk("hlt_flush", hlt, 1'b1);
        flush = 1'b0;

        // reset clears halt, counter and register file
        rst = 1'b1; tick();
        chk("rst2_hlt", hlt, 1'b0);
        chk("rst2_bubbles", bubbles, 16'd0);
        chk("rst2_valid", oValid, 1'b0);
        rst = 1'b0; settle();
        chk("rst2_ready", ready, 1'b1);
        tick();
        chk("rst2_add_valid", oValid, 1'b1);
        chk("rst2_rf_clear", port0, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
